time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_if.sv | 24 ++
 rtl/time_set_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// Handshake bundle for time_set_ctrl: 1 Hz enable and adjust pulses in, BCD time and mode out.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       adj_hrs;
    logic       adj_min;
    logic       adj_sec;
    logic [1:0] hrs_t;
    logic [3:0] hrs_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic       adjusting;

    modport master (
        output tick_1hz, adj_hrs, adj_min, adj_sec,
        input  hrs_t, hrs_u, min_t, min_u, sec_t, sec_u, adjusting
    );

    modport slave (
        input  tick_1hz, adj_hrs, adj_min, adj_sec,
        output hrs_t, hrs_u, min_t, min_u, sec_t, sec_u, adjusting
    );
endinterface

// File: rtl/time_set_ctrl.sv
// BCD 24h clock with RUN/ADJUST modes; idle ADJUST returns to RUN after HOLDOFF_TICKS ticks.
// Optional macro TIME_SET_CARRY_EN: adjust wraps of seconds/minutes carry into higher fields.
module time_set_ctrl #(
    parameter int HOLDOFF_TICKS = 4
) (
    input logic           clk,
    input logic           reset,
    time_set_ctrl_if.slave bus
);
    typedef enum logic {RUN, ADJUST} state_t;

    localparam logic [3:0] IDLE_LAST = 4'(HOLDOFF_TICKS - 1);

    state_t     state_q;
    logic       adjusting_q;
    logic [3:0] idle_q;
    logic [1:0] hrs_t_q, hrs_t_d;
    logic [3:0] hrs_u_q, hrs_u_d;
    logic [2:0] min_t_q, min_t_d;
    logic [3:0] min_u_q, min_u_d;
    logic [2:0] sec_t_q, sec_t_d;
    logic [3:0] sec_u_q, sec_u_d;

    logic adj_any, tick_adv, win_hrs, win_min, win_sec;
    logic sec_wrap, min_wrap, hrs_wrap;
    logic step_sec, step_min, step_hrs;

    always_comb begin
        adj_any  = bus.adj_hrs | bus.adj_min | bus.adj_sec;
        win_hrs  = bus.adj_hrs;
        win_min  = bus.adj_min & ~bus.adj_hrs;
        win_sec  = bus.adj_sec & ~bus.adj_min & ~bus.adj_hrs;
        tick_adv = (state_q == RUN) & bus.tick_1hz & ~adj_any;

        sec_wrap = (sec_t_q == 3'd5) && (sec_u_q == 4'd9);
        min_wrap = (min_t_q == 3'd5) && (min_u_q == 4'd9);
        hrs_wrap = (hrs_t_q == 2'd2) && (hrs_u_q == 4'd3);

        step_sec = tick_adv | win_sec;
        step_min = (tick_adv & sec_wrap) | win_min;
        step_hrs = (tick_adv & sec_wrap & min_wrap) | win_hrs;
`ifdef TIME_SET_CARRY_EN
        step_min = step_min | (win_sec & sec_wrap);
        step_hrs = step_hrs | (win_min & min_wrap) | (win_sec & sec_wrap & min_wrap);
`endif

        sec_t_d = sec_t_q;
        sec_u_d = sec_u_q;
        if (step_sec) begin
            if (sec_u_q == 4'd9) begin
                sec_u_d = 4'd0;
                sec_t_d = sec_wrap ? 3'd0 : sec_t_q + 3'd1;
            end else begin
                sec_u_d = sec_u_q + 4'd1;
            end
        end

        min_t_d = min_t_q;
        min_u_d = min_u_q;
        if (step_min) begin
            if (min_u_q == 4'd9) begin
                min_u_d = 4'd0;
                min_t_d = min_wrap ? 3'd0 : min_t_q + 3'd1;
            end else begin
                min_u_d = min_u_q + 4'd1;
            end
        end

        hrs_t_d = hrs_t_q;
        hrs_u_d = hrs_u_q;
        if (step_hrs) begin
            if (hrs_wrap) begin
                hrs_t_d = 2'd0;
                hrs_u_d = 4'd0;
            end else if (hrs_u_q == 4'd9) begin
                hrs_t_d = hrs_t_q + 2'd1;
                hrs_u_d = 4'd0;
            end else begin
                hrs_u_d = hrs_u_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            adjusting_q <= 1'b0;
            idle_q      <= 4'd0;
            hrs_t_q     <= 2'd0;
            hrs_u_q     <= 4'd0;
            min_t_q     <= 3'd0;
            min_u_q     <= 4'd0;
            sec_t_q     <= 3'd0;
            sec_u_q     <= 4'd0;
        end else begin
            hrs_t_q <= hrs_t_d;
            hrs_u_q <= hrs_u_d;
            min_t_q <= min_t_d;
            min_u_q <= min_u_d;
            sec_t_q <= sec_t_d;
            sec_u_q <= sec_u_d;
            case (state_q)
                RUN: begin
                    if (adj_any) begin
                        state_q     <= ADJUST;
                        adjusting_q <= 1'b1;
                        idle_q      <= 4'd0;
                    end
                end
                ADJUST: begin
                    // A tick coincident with an adjust is neither time nor idle.
                    if (adj_any) begin
                        idle_q <= 4'd0;
                    end else if (bus.tick_1hz) begin
                        if (idle_q == IDLE_LAST) begin
                            state_q     <= RUN;
                            adjusting_q <= 1'b0;
                            idle_q      <= 4'd0;
                        end else begin
                            idle_q <= idle_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= RUN;
                    adjusting_q <= 1'b0;
                    idle_q      <= 4'd0;
                end
            endcase
        end
    end

    assign bus.hrs_t     = hrs_t_q;
    assign bus.hrs_u     = hrs_u_q;
    assign bus.min_t     = min_t_q;
    assign bus.min_u     = min_u_q;
    assign bus.sec_t     = sec_t_q;
    assign bus.sec_u     = sec_u_q;
    assign bus.adjusting = adjusting_q;
endmodule
